// File: rtl/ip_pkg.sv
// IPv4 field constants, receive-parser state enum and ones'-complement fold helper,
// shared by the RX deframer and the TX encapsulation block.
package ip_pkg;

   localparam logic [3:0]  IP_VER_4          = 4'h4;
   localparam logic [3:0]  IP_IHL_MIN        = 4'h5;
   localparam logic [7:0]  IP_PROTO_TCP      = 8'h06;
   localparam logic [7:0]  IP_PROTO_UDP      = 8'h11;
   localparam int unsigned IP_HDR_WORDS      = 5;
   localparam logic [31:0] IP_ADDR_LOCAL_DEF = 32'hC0A80001;

   typedef enum logic [1:0] {
      ST_HDR,
      ST_PAYLOAD,
      ST_DROP
   } ip_rx_state_e;

   // Two folds are enough: the first leaves at most a single carry bit.
   function automatic logic [15:0] csum_fold(input logic [17:0] acc);
      logic [16:0] s1;
      s1 = {1'b0, acc[15:0]} + {15'b0, acc[17:16]};
      return s1[15:0] + {15'b0, s1[16]};
   endfunction

endpackage

// File: rtl/ip_csum16.sv
// Incremental 16-bit ones'-complement accumulator: clear, add one 32-bit word per cycle,
// and a folded result that already includes the word being added this cycle.
module ip_csum16
   import ip_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        add,
   input  logic [31:0] word,
   output logic [15:0] sum_next
);

   logic [17:0] acc;
   logic [17:0] acc_base;
   logic [17:0] acc_next;

   // Folding the stored carries before each add keeps the sum inside 18 bits for any header.
   always_comb begin
      acc_base = clr ? 18'd0 : ({2'b0, acc[15:0]} + {16'b0, acc[17:16]});
      acc_next = acc_base;
      if (add) begin
         acc_next = acc_base + {2'b0, word[31:16]} + {2'b0, word[15:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 18'd0;
      end else if (clr || add) begin
         acc <= acc_next;
      end
   end

   assign sum_next = csum_fold(acc_next);

endmodule

// File: rtl/ip_rx_parser.sv
// Receive-side IPv4 deframer: validates the option-free 20-byte header, strips it and
// forwards the payload to TCP. Header checksum checking is built only with IP_RX_CSUM_EN.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  ST_HDR     | consuming header words 0..4 (idx), always ready
//  ST_PAYLOAD | copying payload words into the 1-deep TCP output register
//  ST_DROP    | swallowing the rest of a rejected packet until eth_rx_last
module ip_rx_parser
   import ip_pkg::*;
#(
   parameter logic [3:0]  IP_VERSION      = IP_VER_4,
   parameter logic [3:0]  IP_IHL          = IP_IHL_MIN,
   parameter logic [7:0]  IP_PROTOCOL_TCP = IP_PROTO_TCP,
   parameter logic [31:0] IP_ADDR_LOCAL   = IP_ADDR_LOCAL_DEF,
   parameter int unsigned DROP_CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           eth_rx_data,
   input  logic                  eth_rx_valid,
   input  logic                  eth_rx_last,
   output logic                  eth_rx_ready,
   output logic [31:0]           tcp_rx_data,
   output logic                  tcp_rx_valid,
   output logic                  tcp_rx_last,
   input  logic                  tcp_rx_ready,
   output logic                  pkt_ok,
   output logic                  pkt_drop,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam logic [2:0] IDX_LAST = 3'(IP_HDR_WORDS - 1);

   ip_rx_state_e state;
   logic [2:0]   idx;
   logic         hdr_bad;
   logic         eth_acc;
   logic         hdr_acc;
   logic         csum_ok;
   logic         word_bad;
   logic         bad_so_far;
   logic         ok_now;
   logic         drop_now;

   assign eth_rx_ready = (state == ST_PAYLOAD) ? (!tcp_rx_valid || tcp_rx_ready) : 1'b1;
   assign eth_acc      = eth_rx_valid && eth_rx_ready;
   assign hdr_acc      = eth_acc && (state == ST_HDR);

`ifdef IP_RX_CSUM_EN
   logic [15:0] csum_sum;

   ip_csum16 u_csum (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (idx == 3'd0),
      .add      (hdr_acc),
      .word     (eth_rx_data),
      .sum_next (csum_sum)
   );

   assign csum_ok = (csum_sum == 16'hFFFF);
`else
   assign csum_ok = 1'b1;
`endif

   // Source address (w3) and total length are deliberately not checked; payload ends at last.
   always_comb begin
      word_bad = 1'b0;
      case (idx)
         3'd0:    word_bad = (eth_rx_data[31:28] != IP_VERSION) || (eth_rx_data[27:24] != IP_IHL);
         3'd1:    word_bad = eth_rx_data[13] || (eth_rx_data[12:0] != 13'd0);
         3'd2:    word_bad = (eth_rx_data[23:16] != IP_PROTOCOL_TCP);
         3'd4:    word_bad = (eth_rx_data != IP_ADDR_LOCAL) || !csum_ok;
         default: word_bad = 1'b0;
      endcase
      bad_so_far = (idx == 3'd0) ? word_bad : (hdr_bad || word_bad);
      ok_now     = hdr_acc && (idx == IDX_LAST) && !bad_so_far;
      drop_now   = hdr_acc && ((idx == IDX_LAST) ? bad_so_far : eth_rx_last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_HDR;
         idx          <= 3'd0;
         hdr_bad      <= 1'b0;
         tcp_rx_data  <= 32'd0;
         tcp_rx_valid <= 1'b0;
         tcp_rx_last  <= 1'b0;
         pkt_ok       <= 1'b0;
         pkt_drop     <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         pkt_ok   <= ok_now;
         pkt_drop <= drop_now;
         if (drop_now && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
         end

         // Output register drains independently of the parser state.
         if (tcp_rx_ready) begin
            tcp_rx_valid <= 1'b0;
            tcp_rx_last  <= 1'b0;
         end

         if (eth_acc) begin
            case (state)
               ST_HDR: begin
                  hdr_bad <= bad_so_far;
                  if (idx == IDX_LAST) begin
                     idx <= 3'd0;
                     if (!eth_rx_last) begin
                        state <= bad_so_far ? ST_DROP : ST_PAYLOAD;
                     end
                  end else if (eth_rx_last) begin
                     idx <= 3'd0;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
               ST_PAYLOAD: begin
                  tcp_rx_valid <= 1'b1;
                  tcp_rx_data  <= eth_rx_data;
                  tcp_rx_last  <= eth_rx_last;
                  if (eth_rx_last) begin
                     state <= ST_HDR;
                  end
               end
               ST_DROP: begin
                  if (eth_rx_last) begin
                     state <= ST_HDR;
                  end
               end
               default: state <= ST_HDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ip_rx_parser.sv
// Self-checking bench for ip_rx_parser: directed scenarios plus randomized packets
// scored against a packet-level model of the header rules.
module tb_ip_rx_parser;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] eth_rx_data;
   logic        eth_rx_valid;
   logic        eth_rx_last;
   logic        eth_rx_ready;
   logic [31:0] tcp_rx_data;
   logic        tcp_rx_valid;
   logic        tcp_rx_last;
   logic        tcp_rx_ready;
   logic        pkt_ok;
   logic        pkt_drop;
   logic [15:0] drop_cnt;

   localparam logic [31:0] LOCAL = 32'hC0A80001;

   ip_rx_parser dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .eth_rx_data  (eth_rx_data),
      .eth_rx_valid (eth_rx_valid),
      .eth_rx_last  (eth_rx_last),
      .eth_rx_ready (eth_rx_ready),
      .tcp_rx_data  (tcp_rx_data),
      .tcp_rx_valid (tcp_rx_valid),
      .tcp_rx_last  (tcp_rx_last),
      .tcp_rx_ready (tcp_rx_ready),
      .pkt_ok       (pkt_ok),
      .pkt_drop     (pkt_drop),
      .drop_cnt     (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [32:0] got_q[$];
   logic [32:0] exp_q[$];
   int got_ok, got_drop, exp_ok, exp_drop, exp_cnt, stalls;
   int rdy_mode = 0;
   logic [31:0] hdr[5];

   always @(negedge clk) begin
      if (rst_n) begin
         if (tcp_rx_valid && tcp_rx_ready) got_q.push_back({tcp_rx_last, tcp_rx_data});
         if (pkt_ok)   got_ok++;
         if (pkt_drop) got_drop++;
      end
   end

   initial begin
      tcp_rx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       tcp_rx_ready = 1'b1;
            1:       tcp_rx_ready = !tcp_rx_ready;
            default: tcp_rx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   function automatic logic [15:0] ones_sum(input logic [31:0] w[$]);
      int s = 0;
      for (int i = 0; i < 5; i++) s += int'(w[i][31:16]) + int'(w[i][15:0]);
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      return 16'(s);
   endfunction

   // Packet-level reference: verdict from the header rules, payload = words after the header.
   function automatic void model_pkt(input logic [31:0] w[$]);
      int  n = w.size();
      bit  good;
      if (n < 5) begin
         exp_drop++;
         if (exp_cnt < 65535) exp_cnt++;
         return;
      end
      good = (w[0][31:28] == 4'h4) && (w[0][27:24] == 4'h5) && (w[1][13] == 1'b0) &&
             (w[1][12:0] == 13'd0) && (w[2][23:16] == 8'h06) && (w[4] == LOCAL);
`ifdef IP_RX_CSUM_EN
      good = good && (ones_sum(w) == 16'hFFFF);
`endif
      if (!good) begin
         exp_drop++;
         if (exp_cnt < 65535) exp_cnt++;
      end else begin
         exp_ok++;
         for (int i = 5; i < n; i++) exp_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, w[i]});
      end
   endfunction

   function automatic void make_hdr(input logic [3:0] ver, input logic [3:0] ihl,
                                    input logic [31:0] w1, input logic [7:0] proto,
                                    input logic [31:0] dst, input logic [15:0] tot);
      logic [31:0] q[$];
      hdr[0] = {ver, ihl, 8'h00, tot};
      hdr[1] = w1;
      hdr[2] = {8'h40, proto, 16'h0000};
      hdr[3] = $urandom;
      hdr[4] = dst;
      for (int i = 0; i < 5; i++) q.push_back(hdr[i]);
      hdr[2][15:0] = ~ones_sum(q);
   endfunction

   function automatic int count_mismatch();
      int m = 0;
      int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) m++;
      m += (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
      return m;
   endfunction

   task automatic start_test();
      got_q.delete();
      exp_q.delete();
      got_ok = 0; got_drop = 0; exp_ok = 0; exp_drop = 0; stalls = 0;
   endtask

   task automatic drain();
      rdy_mode = 0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      eth_rx_valid = 1'b0; eth_rx_last = 1'b0; eth_rx_data = 32'd0;
      exp_cnt = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic send_pkt(input logic [31:0] w[$], input bit gaps, input int abort_at);
      int n = w.size();
      bit acc;
      int tries;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            eth_rx_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
         end
         eth_rx_data = w[i]; eth_rx_valid = 1'b1; eth_rx_last = (i == n - 1);
         acc = 1'b0; tries = 0;
         while (!acc) begin
            @(negedge clk);
            acc = eth_rx_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            tries++;
            if (!acc && tries > 200) begin
               n_tests++; n_fail++;
               $display("FAIL send_timeout word %0d: eth_rx_ready=%b, required 1", i, eth_rx_ready);
               eth_rx_valid = 1'b0; eth_rx_last = 1'b0;
               return;
            end
         end
         if (i == abort_at) break;
      end
      eth_rx_valid = 1'b0; eth_rx_last = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests += 7;
      if (tcp_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", tcp_rx_valid); end
      if (tcp_rx_last  !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", tcp_rx_last); end
      if (tcp_rx_data  !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", tcp_rx_data); end
      if (pkt_ok       !== 1'b0) begin n_fail++; $display("FAIL reset_ok got %b want 0", pkt_ok); end
      if (pkt_drop     !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0", pkt_drop); end
      if (drop_cnt     !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", drop_cnt); end
      if (eth_rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", eth_rx_ready); end
   endtask

   task automatic test_valid();
      logic [31:0] p[$];
      start_test();
      rdy_mode = 0;
      p = '{32'h45000018, 32'h00000000, 32'h4006F98C, 32'hC0A80002, 32'hC0A80001, 32'hDEADBEEF};
      model_pkt(p);
      send_pkt(p, 1'b0, -1);
      n_tests += 3;
      if (tcp_rx_valid !== 1'b1) begin n_fail++; $display("FAIL valid_latency_valid got %b want 1", tcp_rx_valid); end
      if (tcp_rx_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL valid_latency_data got %h want deadbeef", tcp_rx_data); end
      if (tcp_rx_last !== 1'b1) begin n_fail++; $display("FAIL valid_latency_last got %b want 1", tcp_rx_last); end
      drain();
      n_tests += 4;
      if (got_ok !== 1) begin n_fail++; $display("FAIL valid_ok_pulses got %0d want 1", got_ok); end
      if (got_drop !== 0) begin n_fail++; $display("FAIL valid_drop_pulses got %0d want 0", got_drop); end
      if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL valid_cnt got %0d want 0", drop_cnt); end
      if (count_mismatch() !== 0) begin n_fail++; $display("FAIL valid_payload got %0d words want %0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic test_bad_csum();
      logic [31:0] p[$];
      start_test();
      p = '{32'h45000018, 32'h00000000, 32'h4006F98D, 32'hC0A80002, 32'hC0A80001, 32'hDEADBEEF};
      model_pkt(p);
      send_pkt(p, 1'b0, -1);
      drain();
      n_tests += 4;
      if (got_ok !== exp_ok) begin n_fail++; $display("FAIL csum_ok got %0d want %0d", got_ok, exp_ok); end
      if (got_drop !== exp_drop) begin n_fail++; $display("FAIL csum_drop got %0d want %0d", got_drop, exp_drop); end
      if (drop_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL csum_cnt got %0d want %0d", drop_cnt, exp_cnt); end
      if (count_mismatch() !== 0) begin n_fail++; $display("FAIL csum_payload got %0d words want %0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic test_udp();
      logic [31:0] p[$];
      start_test();
      make_hdr(4'h4, 4'h5, 32'h12340000, 8'h11, LOCAL, 16'd60);
      for (int i = 0; i < 5; i++) p.push_back(hdr[i]);
      for (int i = 0; i < 10; i++) p.push_back($urandom);
      model_pkt(p);
      rdy_mode = 2;
      send_pkt(p, 1'b0, -1);
      drain();
      n_tests += 4;
      if (stalls !== 0) begin n_fail++; $display("FAIL udp_stalls got %0d want 0", stalls); end
      if (got_q.size() !== 0) begin n_fail++; $display("FAIL udp_tcp_words got %0d want 0", got_q.size()); end
      if (got_drop !== 1) begin n_fail++; $display("FAIL udp_drop got %0d want 1", got_drop); end
      if (drop_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL udp_cnt got %0d want %0d", drop_cnt, exp_cnt); end
   endtask

   task automatic test_runt();
      logic [31:0] p[$];
      logic [31:0] r[$];
      start_test();
      make_hdr(4'h4, 4'h5, 32'h00010000, 8'h06, LOCAL, 16'd28);
      for (int i = 0; i < 3; i++) r.push_back(hdr[i]);
      for (int i = 0; i < 5; i++) p.push_back(hdr[i]);
      p.push_back(32'hA5A50001); p.push_back(32'hA5A50002);
      model_pkt(r);
      model_pkt(p);
      send_pkt(r, 1'b0, -1);
      send_pkt(p, 1'b0, -1);
      drain();
      n_tests += 4;
      if (got_drop !== 1) begin n_fail++; $display("FAIL runt_drop got %0d want 1", got_drop); end
      if (got_ok !== 1) begin n_fail++; $display("FAIL runt_next_ok got %0d want 1", got_ok); end
      if (drop_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL runt_cnt got %0d want %0d", drop_cnt, exp_cnt); end
      if (count_mismatch() !== 0) begin n_fail++; $display("FAIL runt_payload got %0d words want %0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [31:0] p[$];
      start_test();
      make_hdr(4'h4, 4'h5, 32'h00004000, 8'h06, LOCAL, 16'd36);
      for (int i = 0; i < 5; i++) p.push_back(hdr[i]);
      for (int i = 1; i <= 4; i++) p.push_back(32'(i));
      model_pkt(p);
      rdy_mode = 1;
      send_pkt(p, 1'b0, -1);
      drain();
      n_tests += 3;
      if (got_q.size() !== 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got_q.size()); end
      if (count_mismatch() !== 0) begin n_fail++; $display("FAIL bp_order got %0d mismatches want 0", count_mismatch()); end
      if (got_ok !== 1) begin n_fail++; $display("FAIL bp_ok got %0d want 1", got_ok); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] p[$];
      logic [31:0] q[$];
      start_test();
      rdy_mode = 0;
      make_hdr(4'h4, 4'h5, 32'h00000000, 8'h06, LOCAL, 16'd36);
      for (int i = 0; i < 5; i++) p.push_back(hdr[i]);
      p.push_back(32'h0000A001); p.push_back(32'h0000A002);
      p.push_back(32'h0000A003); p.push_back(32'h0000A004);
      exp_ok = 1;
      exp_q.push_back({1'b0, 32'h0000A001});
      send_pkt(p, 1'b0, 6);
      rst_n = 1'b0;
      exp_cnt = 0;
      #1;
      n_tests += 4;
      if (tcp_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", tcp_rx_valid); end
      if (tcp_rx_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", tcp_rx_data); end
      if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_cnt got %0d want 0", drop_cnt); end
      if (eth_rx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", eth_rx_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      make_hdr(4'h4, 4'h5, 32'h00000000, 8'h06, LOCAL, 16'd28);
      for (int i = 0; i < 5; i++) q.push_back(hdr[i]);
      q.push_back(32'h0000B001); q.push_back(32'h0000B002);
      model_pkt(q);
      send_pkt(q, 1'b0, -1);
      drain();
      n_tests += 3;
      if (got_ok !== exp_ok) begin n_fail++; $display("FAIL rstmid_ok got %0d want %0d", got_ok, exp_ok); end
      if (got_drop !== 0) begin n_fail++; $display("FAIL rstmid_drop got %0d want 0", got_drop); end
      if (count_mismatch() !== 0) begin n_fail++; $display("FAIL rstmid_payload got %0d words want %0d", got_q.size(), exp_q.size()); end
   endtask

   task automatic test_random();
      logic [31:0] p[$];
      logic [3:0]  ver, ihl;
      logic [31:0] w1, dst;
      logic [7:0]  proto;
      int kind, plen;
      start_test();
      for (int k = 0; k < 60; k++) begin
         kind  = $urandom_range(0, 9);
         plen  = $urandom_range(0, 5);
         ver   = 4'h4; ihl = 4'h5; proto = 8'h06; dst = LOCAL;
         w1    = {16'($urandom), 1'b0, 1'($urandom_range(0, 1)), 14'd0};
         case (kind)
            1: ver   = 4'h6;
            2: ihl   = 4'h6;
            3: w1[13] = 1'b1;
            4: w1[12:0] = 13'($urandom_range(1, 8191));
            5: proto = 8'h11;
            6: dst   = LOCAL ^ (32'd1 << $urandom_range(0, 31));
            9: plen  = 0;
            default: ;
         endcase
         make_hdr(ver, ihl, w1, proto, dst, 16'(20 + 4 * plen));
         if (kind == 7) hdr[3] = hdr[3] ^ (32'd1 << $urandom_range(0, 31));
         p.delete();
         for (int i = 0; i < 5; i++) p.push_back(hdr[i]);
         for (int i = 0; i < plen; i++) p.push_back($urandom);
         if (kind == 8) while (p.size() > 1 && p.size() > $urandom_range(1, 4)) void'(p.pop_back());
         model_pkt(p);
         rdy_mode = $urandom_range(0, 2);
         send_pkt(p, 1'b1, -1);
      end
      drain();
      n_tests += 4;
      if (got_ok !== exp_ok) begin n_fail++; $display("FAIL rand_ok got %0d want %0d", got_ok, exp_ok); end
      if (got_drop !== exp_drop) begin n_fail++; $display("FAIL rand_drop got %0d want %0d", got_drop, exp_drop); end
      if (drop_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rand_cnt got %0d want %0d", drop_cnt, exp_cnt); end
      if (count_mismatch() !== 0) begin n_fail++; $display("FAIL rand_payload got %0d words want %0d (%0d differ)", got_q.size(), exp_q.size(), count_mismatch()); end
   endtask

   initial begin
      rst_n = 1'b0;
      eth_rx_valid = 1'b0; eth_rx_last = 1'b0; eth_rx_data = 32'd0;
      test_reset();
      test_valid();
      test_bad_csum();
      test_udp();
      test_runt();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
